board_line_clear: RTL and testbench
===================================

BOARD_LINE_CLEAR -- requirements
Module: board_line_clear

Interface
REQ-001 SHALL have parameter BLOCKS_IN_ROW, default 20, meaning number of board rows (index 0 top, 19 bottom).
REQ-002 SHALL have parameter BLOCKS_IN_COL, default 10, meaning cells per row.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to clear full rows and compact the board.
REQ-006 SHALL have port board  input  200  current board; row r at board[r*10 +: 10], bit 9 rightmost, bit 0 leftmost.
REQ-007 SHALL have port ready_from_board  input  1  board store idle and accepting a request.
REQ-008 SHALL have port resp_from_board  input  1  board store has written the current row.
REQ-009 SHALL have port req_save_to_board  output  1  row-write request to the board store.
REQ-010 SHALL have port row_idx  output  6  destination row index, 0..19.
REQ-011 SHALL have port row_info  output  10  row data to write.
REQ-012 SHALL have port busy  output  1  high from the accepted start until done.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port lines_cleared  output  5  number of full rows removed by the last operation, 0..20.

Function
REQ-015 SHALL use states IDLE, SCAN, ISSUE, WAIT_RESP, WAIT_READY, DONE.
REQ-016 SHALL, in IDLE on start=1, capture board into an internal snapshot, set busy=1, and go to SCAN; start SHALL be ignored in all other states.
REQ-017 SHALL treat a snapshot row as full when all 10 bits are 1.
REQ-018 SHALL, in SCAN (exactly one cycle), load lines_cleared with the count of full rows, then go to DONE if the count is 0, else to ISSUE with read pointer rd=19 and write pointer wr=19.
REQ-019 SHALL, in ISSUE, while rd is valid and snapshot row rd is full, decrement rd by one row per cycle without issuing a request.
REQ-020 SHALL, in ISSUE with a non-full or exhausted rd and ready_from_board=1, drive row_idx=wr, row_info=snapshot row rd (or 10'b0 if rd is exhausted), req_save_to_board=1, and go to WAIT_RESP.
REQ-021 SHALL hold req_save_to_board, row_idx and row_info stable throughout WAIT_RESP.
REQ-022 SHALL, in WAIT_RESP on resp_from_board=1, deassert req_save_to_board at the next edge; it SHALL go to DONE if wr=0, else decrement wr, decrement rd if it is not exhausted, and go to WAIT_READY.
REQ-023 SHALL, in WAIT_READY, keep req_save_to_board=0 and go to ISSUE once ready_from_board=1.
REQ-024 SHALL issue exactly 20 write transactions when lines_cleared>0, to rows 19 down to 0 in order.
REQ-025 SHALL never assert req_save_to_board for two consecutive transactions without at least one intervening low cycle.
REQ-026 SHALL, in DONE, pulse done=1 for one cycle, clear busy, and return to IDLE; lines_cleared SHALL hold until the next SCAN.
REQ-027 SHALL read only the snapshot during an operation; changes on board after capture have no effect.
REQ-028 SHALL leave req_save_to_board low in IDLE, SCAN and DONE.

Reset
REQ-029 SHALL, on rst=1 at a rising edge, enter IDLE and set req_save_to_board=0, row_idx=0, row_info=0, busy=0, done=0, lines_cleared=0.
REQ-030 SHALL give rst priority over start and over all in-flight transactions; a reset in WAIT_RESP drops req at that edge, and no partial operation resumes.

Verification
REQ-031 SHALL pass: empty board, start -> SCAN, done two cycles after start, lines_cleared=0, no req.
REQ-032 SHALL pass: row 19=10'h3FF, row 18=10'h001, others 0 -> 20 writes, row 19 gets 10'h001, rows 18..0 get 0, lines_cleared=1.
REQ-033 SHALL pass: rows 19, 17 full, row 18=10'h155, row 16=10'h2AA -> row 19 gets 10'h155, row 18 gets 10'h2AA, rows 17..0 get 0, lines_cleared=2.
REQ-034 SHALL pass: all 20 rows full -> 20 writes of 10'h000, lines_cleared=20.
REQ-035 SHALL pass: board store delays resp_from_board by 3 cycles and holds ready_from_board low for 2 cycles -> req, row_idx and row_info stable until resp; no req while ready=0.
REQ-036 SHALL pass: rst asserted in WAIT_RESP of the 5th write -> next cycle req=0, busy=0, state IDLE; a new start then runs a full clean operation.

Source files
------------

// File: rtl/board_line_clear.sv
// Board line clear: snapshots the board, counts full rows, then rewrites
// every row bottom-up with the full rows squeezed out and zeros on top.
module board_line_clear #(
  parameter int unsigned BLOCKS_IN_ROW = 20,
  parameter int unsigned BLOCKS_IN_COL = 10,
  localparam int unsigned CNT_W = $clog2(BLOCKS_IN_ROW + 1),
  localparam int unsigned IDX_W = 6
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [BLOCKS_IN_ROW*BLOCKS_IN_COL-1:0] board,
  input  logic                                   ready_from_board,
  input  logic                                   resp_from_board,
  output logic                                   req_save_to_board,
  output logic [IDX_W-1:0]                       row_idx,
  output logic [BLOCKS_IN_COL-1:0]               row_info,
  output logic                                   busy,
  output logic                                   done,
  output logic [CNT_W-1:0]                       lines_cleared
);

  localparam int unsigned PTR_W = $clog2(BLOCKS_IN_ROW);
  localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(BLOCKS_IN_ROW - 1);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    ISSUE,
    WAIT_RESP,
    WAIT_READY,
    DONE
  } state_t;

  state_t                   state;
  logic [BLOCKS_IN_COL-1:0] snap [BLOCKS_IN_ROW];
  logic [BLOCKS_IN_ROW-1:0] full_rows;
  logic [CNT_W-1:0]         full_cnt;
  logic [PTR_W-1:0]         rd;
  logic [PTR_W-1:0]         wr;
  logic                     rd_valid;

  // Snapshot of the board, taken only when a request is accepted
  always_ff @(posedge clk) begin
    if (state == IDLE && start && !rst) begin
      for (int r = 0; r < BLOCKS_IN_ROW; r++) begin
        snap[r] <= board[r*BLOCKS_IN_COL +: BLOCKS_IN_COL];
      end
    end
  end

  // Per-row full flags and their population count
  always_comb begin
    full_cnt = '0;
    for (int r = 0; r < BLOCKS_IN_ROW; r++) begin
      full_rows[r] = &snap[r];
      full_cnt     = full_cnt + CNT_W'(full_rows[r]);
    end
  end

  // Control FSM with registered outputs; rd stays at 0 once exhausted
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      req_save_to_board <= 1'b0;
      row_idx           <= '0;
      row_info          <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      lines_cleared     <= '0;
      rd                <= '0;
      wr                <= '0;
      rd_valid          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            state <= SCAN;
          end
        end

        SCAN: begin
          lines_cleared <= full_cnt;
          rd            <= LAST_ROW;
          wr            <= LAST_ROW;
          rd_valid      <= 1'b1;
          if (full_cnt == '0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            state <= ISSUE;
          end
        end

        ISSUE: begin
          if (rd_valid && full_rows[rd]) begin
            rd_valid <= (rd != '0);
            if (rd != '0) rd <= rd - PTR_W'(1);
          end else if (ready_from_board) begin
            req_save_to_board <= 1'b1;
            row_idx           <= IDX_W'(wr);
            row_info          <= rd_valid ? snap[rd] : '0;
            state             <= WAIT_RESP;
          end
        end

        WAIT_RESP: begin
          if (resp_from_board) begin
            req_save_to_board <= 1'b0;
            if (wr == '0) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              wr <= wr - PTR_W'(1);
              if (rd_valid) begin
                rd_valid <= (rd != '0);
                if (rd != '0) rd <= rd - PTR_W'(1);
              end
              state <= WAIT_READY;
            end
          end
        end

        WAIT_READY: begin
          if (ready_from_board) state <= ISSUE;
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_line_clear.sv
// Directed bench for board_line_clear with a scoreboard of expected row writes
// and a behavioural board store with configurable response/ready latency.
module tb_board_line_clear;

  localparam int unsigned R = 20;
  localparam int unsigned C = 10;

  logic           clk;
  logic           rst;
  logic           start;
  logic [R*C-1:0] board;
  logic           ready_from_board;
  logic           resp_from_board;
  logic           req_save_to_board;
  logic [5:0]     row_idx;
  logic [C-1:0]   row_info;
  logic           busy;
  logic           done;
  logic [4:0]     lines_cleared;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;
  logic [15:0] exp_q [$];

  // board store model knobs and state
  int resp_delay = 0;
  int ready_low  = 0;
  int pend_dly   = 0;
  int low_cnt    = 0;
  bit pend       = 0;

  board_line_clear #(.BLOCKS_IN_ROW(R), .BLOCKS_IN_COL(C)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .board             (board),
    .ready_from_board  (ready_from_board),
    .resp_from_board   (resp_from_board),
    .req_save_to_board (req_save_to_board),
    .row_idx           (row_idx),
    .row_info          (row_info),
    .busy              (busy),
    .done              (done),
    .lines_cleared     (lines_cleared)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference compaction: keep non-full rows bottom-up, pad with zeros
  function automatic int push_expected(input logic [R*C-1:0] b);
    logic [C-1:0] kept [$];
    logic [C-1:0] row;
    logic [C-1:0] data;
    int full = 0;
    for (int r = R - 1; r >= 0; r--) begin
      row = b[r*C +: C];
      if (&row) full++;
      else kept.push_back(row);
    end
    if (full > 0) begin
      for (int w = R - 1; w >= 0; w--) begin
        if (kept.size() > 0) data = kept.pop_front();
        else data = '0;
        exp_q.push_back({6'(w), data});
      end
    end
    return full;
  endfunction

  // Board store: answers each request after resp_delay cycles, then stays
  // not-ready for ready_low cycles
  always @(negedge clk) begin
    resp_from_board = 1'b0;
    if (rst) begin
      pend    = 0;
      low_cnt = 0;
    end else if (pend) begin
      if (pend_dly == 0) begin
        resp_from_board = 1'b1;
        pend    = 0;
        low_cnt = ready_low;
      end else begin
        pend_dly--;
      end
    end else if (low_cnt > 0) begin
      low_cnt--;
    end else if (req_save_to_board) begin
      pend     = 1;
      pend_dly = resp_delay;
    end
    ready_from_board = !pend && (low_cnt == 0);
  end

  // Write monitor: new requests are popped against the scoreboard,
  // held requests must keep index and data stable
  logic        req_q = 1'b0;
  logic [15:0] hold  = '0;
  always @(posedge clk) begin
    logic rdy_at_edge;
    logic [15:0] e;
    rdy_at_edge = ready_from_board;
    #1;
    if (req_save_to_board && !req_q) begin
      wr_count++;
      check("req_while_not_ready", 32'(rdy_at_edge), 1);
      check("req_with_empty_queue", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("write_idx_data", {16'h0, row_idx, row_info}, {16'h0, e});
      end
    end else if (req_save_to_board && req_q) begin
      check("req_hold_stable", {16'h0, row_idx, row_info}, {16'h0, hold});
    end
    req_q = req_save_to_board;
    hold  = {row_idx, row_info};
  end

  task automatic run_op(input logic [R*C-1:0] b, input string tag, input bit scramble);
    int exp_lines;
    int cyc;
    bit got;
    board = b;
    exp_lines = push_expected(b);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (scramble) board = ~b;
    check({tag, "_busy_high"}, 32'(busy), 1);
    cyc = 1;
    got = done;
    while (!got && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      got = done;
    end
    check({tag, "_done_seen"}, 32'(got), 1);
    if (exp_lines == 0) check({tag, "_done_latency"}, 32'(cyc), 2);
    check({tag, "_lines_cleared"}, 32'(lines_cleared), 32'(exp_lines));
    check({tag, "_busy_low"}, 32'(busy), 0);
    check({tag, "_writes_left"}, 32'(exp_q.size()), 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 0);
    check({tag, "_lines_hold"}, 32'(lines_cleared), 32'(exp_lines));
    exp_q.delete();
  endtask

  function automatic logic [R*C-1:0] set_row(input logic [R*C-1:0] b, input int r, input logic [C-1:0] v);
    logic [R*C-1:0] t;
    t = b;
    t[r*C +: C] = v;
    return t;
  endfunction

  initial begin
    logic [R*C-1:0] b;
    int base;
    int cyc;
    rst   = 1'b1;
    start = 1'b0;
    board = '0;
    ready_from_board = 1'b1;
    resp_from_board  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(req_save_to_board), 0);
    check("rst_row_idx", 32'(row_idx), 0);
    check("rst_row_info", 32'(row_info), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_lines", 32'(lines_cleared), 0);
    rst = 1'b0;
    @(negedge clk);

    // empty board
    base = wr_count;
    run_op('0, "empty", 1'b0);
    check("empty_no_writes", 32'(wr_count - base), 0);

    // single full bottom row
    b = set_row('0, 19, 10'h3FF);
    b = set_row(b, 18, 10'h001);
    base = wr_count;
    run_op(b, "one_line", 1'b0);
    check("one_line_writes", 32'(wr_count - base), 20);

    // interleaved full rows; board changed after capture
    b = set_row('0, 19, 10'h3FF);
    b = set_row(b, 18, 10'h155);
    b = set_row(b, 17, 10'h3FF);
    b = set_row(b, 16, 10'h2AA);
    run_op(b, "two_lines", 1'b1);

    // every row full
    base = wr_count;
    run_op('1, "all_full", 1'b0);
    check("all_full_writes", 32'(wr_count - base), 20);

    // slow board store
    resp_delay = 3;
    ready_low  = 2;
    b = set_row('0, 19, 10'h3FF);
    b = set_row(b, 18, 10'h001);
    b = set_row(b, 10, 10'h3FF);
    b = set_row(b, 5, 10'h0F0);
    run_op(b, "slow_store", 1'b0);

    // random boards
    resp_delay = 1;
    ready_low  = 1;
    for (int k = 0; k < 2; k++) begin
      b = '0;
      for (int r = 0; r < R; r++) begin
        if ($urandom_range(0, 2) == 0) b = set_row(b, r, 10'h3FF);
        else b = set_row(b, r, C'($urandom));
      end
      b = set_row(b, 3, 10'h3FF);
      run_op(b, "random", 1'b0);
    end

    // reset during the 5th write
    resp_delay = 3;
    ready_low  = 1;
    b = set_row('0, 19, 10'h3FF);
    b = set_row(b, 12, 10'h3C3);
    board = b;
    void'(push_expected(b));
    base = wr_count;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(wr_count >= base + 5 && req_save_to_board) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst_reached_5th", 32'(wr_count - base), 5);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_req", 32'(req_save_to_board), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_lines", 32'(lines_cleared), 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("midrst_idle_req", 32'(req_save_to_board), 0);
    resp_delay = 0;
    ready_low  = 0;
    base = wr_count;
    run_op(b, "after_rst", 1'b0);
    check("after_rst_writes", 32'(wr_count - base), 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
